// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_latch_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam logic CMD_SET   = 1'b1;
  localparam logic CMD_RESET = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for one asynchronous level, reset to 0; built only with SR_LATCH_DRIVER_CONFIRM_EN.
// Latency 2 cycles; no handshake, the input is sampled every cycle.
`ifdef SR_LATCH_DRIVER_CONFIRM_EN
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`endif

// File: rtl/sr_latch_driver.sv
// Drives S/R of an async NOR latch: PULSE_W-cycle pulse, GAP_W dead cycles, optional read-back (SR_LATCH_DRIVER_CONFIRM_EN).
// Latency accept->done is PULSE_W+GAP_W+1 cycles plus confirm time; cmd_ready is high only in IDLE.
import sr_latch_driver_pkg::*;

module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S,
  output logic R,
  input  logic q_in,
  input  logic qn_in,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = $clog2(max3(PULSE_W, GAP_W, TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_W);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exp;
  logic             r_s;
  logic             r_r;
  logic             r_done;
  logic             r_err;

`ifdef SR_LATCH_DRIVER_CONFIRM_EN
  localparam logic [CNT_W-1:0] LD_TO = CNT_W'(TIMEOUT);

  logic w_q_sync;
  logic w_qn_sync;
  logic w_match;

  sync2 u_sync_q  (.clk(clk), .rst(rst), .i_d(q_in),  .o_q(w_q_sync));
  sync2 u_sync_qn (.clk(clk), .rst(rst), .i_d(qn_in), .o_q(w_qn_sync));

  // q==qn can never equal {exp,~exp}, so a stuck or metastable latch reads as a mismatch.
  assign w_match = (w_q_sync == r_exp) && (w_qn_sync == ~r_exp);
`else
  logic w_unused_q;
  assign w_unused_q = q_in ^ qn_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_exp   <= CMD_RESET;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_state <= PULSE;
            r_cnt   <= LD_PULSE;
            r_exp   <= cmd_set;
            r_s     <= cmd_set;
            r_r     <= ~cmd_set;
          end
        end
        PULSE: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= GAP;
            r_cnt   <= LD_GAP;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == CNT_ONE) begin
`ifdef SR_LATCH_DRIVER_CONFIRM_EN
            r_state <= CHECK;
            r_cnt   <= LD_TO;
`else
            r_state <= IDLE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef SR_LATCH_DRIVER_CONFIRM_EN
        CHECK: begin
          if (w_match) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (r_cnt == CNT_ONE) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign S         = r_s;
  assign R         = r_r;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous initiator that drives the S/R inputs of an asynchronous SR NOR latch from a valid/ready command interface. It guarantees legal pulse shapes: S and R are never high together, each pulse has a fixed width, and a dead time follows every pulse. An optional read-back stage confirms the latch outputs before reporting completion. It sits between clocked control logic and any cross-coupled latch cell in the sequential library.

## Interface
- PULSE_W, 4: cycles S or R is held high; legal range ≥1.
- GAP_W, 2: dead-time cycles with S=R=0 after each pulse; legal range ≥1.
- TIMEOUT, 16: maximum confirm cycles before error; legal range ≥1. Used only with confirm compiled in.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command request.
- cmd_set  in  1  1 = set latch (pulse S), 0 = reset latch (pulse R); sampled on accept.
- cmd_ready  out  1  high only in IDLE.
- S  out  1  registered set drive to latch.
- R  out  1  registered reset drive to latch.
- q_in  in  1  latch Q, asynchronous to clk.
- qn_in  in  1  latch Qn, asynchronous to clk.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle failure pulse.

## Operation
- States: IDLE, PULSE, GAP, CHECK (CHECK exists only with confirm).
- IDLE: cmd_ready=1. Accept when cmd_valid & cmd_ready; capture cmd_set into exp. Next state is PULSE and the counter is loaded.
- PULSE: S=exp, R=~exp for PULSE_W cycles, then GAP.
- GAP: S=R=0 for GAP_W cycles. The next state is CHECK with confirm, otherwise IDLE with done.
- CHECK: S=R=0. Each cycle compare the synchronized {q,qn} with {exp,~exp}.
  - Match: go to IDLE with done.
  - No match for TIMEOUT cycles: go to IDLE with err.
  - Synchronized q==qn (both low or both high) counts as a mismatch.
- Redundant commands, such as set while already set, are pulsed normally.
- Invariant: S&R==0 in every cycle, including during and after reset.
- Counter: one down-counter, width $clog2(max(PULSE_W,GAP_W,TIMEOUT)+1). It reloads on each state entry. It transitions at count 1, so there is no off-by-one.
- Reset values: S=0, R=0, busy=0, done=0, err=0, cmd_ready=1, state=IDLE, exp=0, synchronizer flops=0.
- Reset mid-operation aborts immediately. S and R fall asynchronously, and no done or err is issued.
- done and err are never high together.

## Timing
- Accept at edge k, meaning cmd_valid=cmd_ready=1 before that edge.
- S or R is high in cycles k+1 through k+PULSE_W.
- Gap occupies cycles k+PULSE_W+1 through k+PULSE_W+GAP_W.
- Without confirm: done=1 and cmd_ready=1 in cycle k+PULSE_W+GAP_W+1. A new command may be accepted in that same cycle, giving back-to-back operation.
- With confirm: read-back has 2-flop synchronizer latency. The earliest done is 1 cycle after CHECK entry, when the synchronized value already matches. Worst case is err at CHECK entry + TIMEOUT cycles.
- done and err are registered. Each is high for exactly the first IDLE cycle after completion.

## Configuration
- SR_LATCH_DRIVER_CONFIRM_EN defined:
  - The CHECK state, the synchronizers and the TIMEOUT logic are built.
  - err can assert.
- SR_LATCH_DRIVER_CONFIRM_EN undefined:
  - No CHECK state and no synchronizers.
  - q_in and qn_in are ignored and err is tied to 0.
  - done follows GAP directly.

## Structure
- Package sr_latch_driver_pkg holds:
  - the state enum typedef (IDLE, PULSE, GAP, CHECK);
  - command encoding constants CMD_SET=1 and CMD_RESET=0.
- Sub-module sync2 is a 2-flop synchronizer with async active-high reset to 0. It is instantiated twice (q_in, qn_in) and only under the macro.

## Test plan
- Reset, then cmd_valid=1, cmd_set=1 accepted at edge 0 (defaults) → S=1 in cycles 1–4; S=R=0 in cycles 5–6; done=1 in cycle 7 (no confirm); R never high.
- Back-to-back: set command, then reset command presented in the done cycle → second accept in that cycle; R=1 for 4 cycles; S&R==0 every cycle.
- Confirm, model latch responds: reset command; latch model yields q_in=0, qn_in=1 → done once, err=0, within 3 cycles of CHECK entry.
- Confirm, stuck latch: q_in=qn_in=0 held; set command → err=1 exactly 16 cycles after CHECK entry; done=0 throughout.
- Reset mid-pulse: assert rst in cycle 2 of an S pulse → S=0 asynchronously; after release cmd_ready=1, busy=0, and no done or err.
- cmd_valid held high while busy → no second capture; cmd_ready=0 until IDLE; changing cmd_set mid-operation does not affect the pulse.
